// File: rtl/ddr_avalon_local_bridge.sv
// Avalon-MM burst slave to DDR2 local_* request bridge; one registered command slot, 1 clk accept-to-request, 1 clk read return.
// Backpressure: waitrequest while calibrating, while the held command is unacknowledged, or while the read-beat budget would overflow.
module ddr_avalon_local_bridge #(
    parameter int ADDR_W   = 25,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int SIZE_W   = 3,
    parameter int MAX_PEND = 16,
    parameter int PEND_W   = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [BE_W-1:0]   avs_byteenable,
    input  logic [SIZE_W-1:0] avs_burstcount,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,

    input  logic              local_init_done,
    input  logic              local_ready,
    input  logic [DATA_W-1:0] local_rdata,
    input  logic              local_rdata_valid,
    output logic [ADDR_W-1:0] local_address,
    output logic              local_read_req,
    output logic              local_write_req,
    output logic              local_burstbegin,
    output logic [SIZE_W-1:0] local_size,
    output logic [DATA_W-1:0] local_wdata,
    output logic [BE_W-1:0]   local_be,

    output logic [PEND_W-1:0] pending_beats,
    output logic              proto_err
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SIZE_W-1:0] beat_cnt;
    logic [SIZE_W-1:0] beat_cnt_next;

    logic              cmd_valid;
    logic              stall;
    logic              rd_block;
    logic              accept;
    logic              wr_accept;
    logic              rd_accept;
    logic              bc_zero;
    logic [SIZE_W-1:0] eff_size;
    logic [PEND_W:0]   pend_sum;
    logic              pend_dec;
    logic              spurious_rdata;

    // A zero burstcount is serviced as a single beat; the flag records the violation.
    assign bc_zero   = (avs_burstcount == '0);
    assign eff_size  = bc_zero ? SIZE_W'(1) : avs_burstcount;

    assign cmd_valid = local_read_req | local_write_req;
    assign stall     = cmd_valid & ~local_ready;

    // One extra bit so the budget comparison cannot wrap.
    assign pend_sum  = {1'b0, pending_beats} + (PEND_W+1)'(eff_size);
    assign rd_block  = avs_read & (pend_sum > (PEND_W+1)'(MAX_PEND));

    assign avs_waitrequest = ~local_init_done
                           | stall
                           | rd_block
                           | ((state == WR_BURST) & avs_read);

    assign accept    = (avs_read | avs_write) & ~avs_waitrequest;
    assign wr_accept = accept & avs_write;
    assign rd_accept = accept & ~avs_write & avs_read;

    assign spurious_rdata = local_rdata_valid & (pending_beats == '0);
    assign pend_dec       = local_rdata_valid & ~spurious_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        case (state)
            IDLE: begin
                if (wr_accept && (eff_size > SIZE_W'(1))) begin
                    state_next    = WR_BURST;
                    beat_cnt_next = eff_size - SIZE_W'(1);
                end
            end
            WR_BURST: begin
                if (wr_accept) begin
                    beat_cnt_next = beat_cnt - SIZE_W'(1);
                    if (beat_cnt == SIZE_W'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                beat_cnt_next = '0;
            end
        endcase
    end

    // Command slot: reloads back-to-back when a new accept lands in the handoff cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            local_address    <= '0;
            local_read_req   <= 1'b0;
            local_write_req  <= 1'b0;
            local_burstbegin <= 1'b0;
            local_size       <= '0;
            local_wdata      <= '0;
            local_be         <= '0;
        end else if (wr_accept) begin
            local_write_req <= 1'b1;
            local_read_req  <= 1'b0;
            local_wdata     <= avs_writedata;
            local_be        <= avs_byteenable;
            if (state == IDLE) begin
                local_burstbegin <= 1'b1;
                local_address    <= avs_address;
                local_size       <= eff_size;
            end else begin
                local_burstbegin <= 1'b0;
            end
        end else if (rd_accept) begin
            local_read_req   <= 1'b1;
            local_write_req  <= 1'b0;
            local_burstbegin <= 1'b1;
            local_address    <= avs_address;
            local_size       <= eff_size;
        end else if (local_ready) begin
            local_read_req   <= 1'b0;
            local_write_req  <= 1'b0;
            local_burstbegin <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_beats <= '0;
        end else begin
            pending_beats <= pending_beats
                           + (rd_accept ? PEND_W'(eff_size) : PEND_W'(0))
                           - PEND_W'(pend_dec);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if ((bc_zero & (rd_accept | (wr_accept & (state == IDLE)))) | spurious_rdata) begin
            proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdata      <= local_rdata;
            avs_readdatavalid <= local_rdata_valid;
        end
    end

endmodule

// File: tb/tb_ddr_avalon_local_bridge.sv
// Bench for ddr_avalon_local_bridge: directed scenarios then randomized master/controller traffic,
// every cycle compared against a transaction-level reference model.
module tb_ddr_avalon_local_bridge;

    localparam int ADDR_W   = 25;
    localparam int DATA_W   = 32;
    localparam int BE_W     = 4;
    localparam int SIZE_W   = 3;
    localparam int MAX_PEND = 16;
    localparam int PEND_W   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [BE_W-1:0]   avs_byteenable;
    logic [SIZE_W-1:0] avs_burstcount;
    logic              avs_waitrequest;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_readdatavalid;
    logic              local_init_done;
    logic              local_ready;
    logic [DATA_W-1:0] local_rdata;
    logic              local_rdata_valid;
    logic [ADDR_W-1:0] local_address;
    logic              local_read_req;
    logic              local_write_req;
    logic              local_burstbegin;
    logic [SIZE_W-1:0] local_size;
    logic [DATA_W-1:0] local_wdata;
    logic [BE_W-1:0]   local_be;
    logic [PEND_W-1:0] pending_beats;
    logic              proto_err;

    always #5 clk = ~clk;

    ddr_avalon_local_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W),
        .SIZE_W(SIZE_W), .MAX_PEND(MAX_PEND), .PEND_W(PEND_W)
    ) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_burstcount(avs_burstcount), .avs_waitrequest(avs_waitrequest),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .local_init_done(local_init_done), .local_ready(local_ready),
        .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
        .local_address(local_address), .local_read_req(local_read_req),
        .local_write_req(local_write_req), .local_burstbegin(local_burstbegin),
        .local_size(local_size), .local_wdata(local_wdata), .local_be(local_be),
        .pending_beats(pending_beats), .proto_err(proto_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the command currently presented, outstanding read beats,
    // remaining beats of the open write burst, and the read data expected next cycle.
    bit          m_known, m_rreq, m_wreq, m_bb, m_burst, m_err, m_rdv, m_acc;
    int          m_addr, m_size, m_left, m_pend;
    logic [31:0] m_wd, m_rd;
    logic [3:0]  m_be;
    logic        obs_wait;

    task automatic model_reset();
        m_known = 1; m_rreq = 0; m_wreq = 0; m_bb = 0; m_burst = 0; m_err = 0;
        m_rdv = 0; m_addr = 0; m_size = 0; m_left = 0; m_pend = 0;
        m_wd = '0; m_rd = '0; m_be = '0;
    endtask

    task automatic check_outputs();
        chk("read_req", local_read_req, m_rreq);
        chk("write_req", local_write_req, m_wreq);
        chk("burstbegin", local_burstbegin, m_bb);
        chk("pending_beats", pending_beats, m_pend);
        chk("proto_err", proto_err, m_err);
        chk("readdatavalid", avs_readdatavalid, m_rdv);
        chk("readdata", avs_readdata, m_rd);
        if (m_rreq || m_wreq) begin
            chk("address", local_address, m_addr);
            chk("size", local_size, m_size);
        end
        if (m_wreq) begin
            chk("wdata", local_wdata, m_wd);
            chk("be", local_be, m_be);
        end
    endtask

    // One clock: predict and check waitrequest mid-cycle, advance the model, check registered outputs after the edge.
    task automatic cycle();
        int bc;
        int np;
        bit exp_wait;
        @(negedge clk);
        obs_wait = avs_waitrequest;
        bc = (avs_burstcount == 0) ? 1 : int'(avs_burstcount);
        exp_wait = !local_init_done || ((m_rreq || m_wreq) && !local_ready)
                || (avs_read && (m_pend + bc > MAX_PEND)) || (m_burst && avs_read);
        if (m_known && !reset) chk("waitrequest", avs_waitrequest, exp_wait);
        m_acc = !reset && (avs_read || avs_write) && !exp_wait;
        if (reset) begin
            model_reset();
        end else begin
            np = m_pend;
            if (local_rdata_valid) begin
                if (m_pend == 0) m_err = 1;
                else np = np - 1;
            end
            m_rdv = local_rdata_valid;
            m_rd  = local_rdata;
            if (m_acc && avs_write) begin
                m_wreq = 1; m_rreq = 0; m_wd = avs_writedata; m_be = avs_byteenable;
                if (m_burst) begin
                    m_bb = 0;
                    m_left = m_left - 1;
                    if (m_left == 0) m_burst = 0;
                end else begin
                    m_bb = 1; m_addr = int'(avs_address); m_size = bc;
                    if (avs_burstcount == 0) m_err = 1;
                    if (bc > 1) begin m_burst = 1; m_left = bc - 1; end
                end
            end else if (m_acc && avs_read) begin
                m_rreq = 1; m_wreq = 0; m_bb = 1; m_addr = int'(avs_address); m_size = bc;
                np = np + bc;
                if (avs_burstcount == 0) m_err = 1;
            end else if (local_ready) begin
                m_rreq = 0; m_wreq = 0; m_bb = 0;
            end
            m_pend = np;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_idle();
        avs_read = 0; avs_write = 0; avs_address = '0; avs_writedata = '0;
        avs_byteenable = '0; avs_burstcount = SIZE_W'(1);
        local_rdata_valid = 0; local_rdata = '0;
    endtask

    int beats, kk, owed, add, mst_left, k;
    bit acc5, mst_active;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        reset = 1; local_init_done = 1; local_ready = 1;
        set_idle();
        repeat (2) cycle();
        chk("rst_address", local_address, 0);
        chk("rst_size", local_size, 0);
        chk("rst_wdata", local_wdata, 0);
        chk("rst_be", local_be, 0);
        reset = 0;
        cycle();
        chk("idle_wait", obs_wait, 0);

        // 1: single write
        avs_write = 1; avs_address = 25'h10; avs_writedata = 32'hA5A5A5A5;
        avs_byteenable = 4'hF; avs_burstcount = 3'd1;
        cycle();
        chk("t1_wait", obs_wait, 0);
        chk("t1_wreq", local_write_req, 1);
        chk("t1_bb", local_burstbegin, 1);
        chk("t1_size", local_size, 1);
        chk("t1_addr", local_address, 32'h10);
        chk("t1_wdata", local_wdata, 32'hA5A5A5A5);
        set_idle();
        cycle();
        chk("t1_wreq_clear", local_write_req, 0);

        // 2: 4-beat write burst, controller not ready in cycles 2-3
        beats = 0;
        for (int c = 0; c < 12 && beats < 4; c++) begin
            local_ready = !(c == 1 || c == 2);
            avs_write = 1; avs_address = 25'h200; avs_burstcount = 3'd4;
            avs_writedata = 32'hB000_0000 + beats; avs_byteenable = 4'hF;
            cycle();
            if (c == 1 || c == 2) chk($sformatf("t2_stall_c%0d", c), obs_wait, 1);
            if (obs_wait === 1'b0) begin
                chk("t2_data", local_wdata, 32'hB000_0000 + beats);
                chk("t2_bb", local_burstbegin, beats == 0);
                chk("t2_addr_held", local_address, 32'h200);
                beats++;
            end
        end
        chk("t2_beats", beats, 4);
        set_idle(); local_ready = 1;
        cycle();
        chk("t2_done", local_write_req, 0);

        // 3: fill the read budget with 4x4-beat reads; fifth waits for returns
        for (int i = 0; i < 4; i++) begin
            avs_read = 1; avs_burstcount = 3'd4; avs_address = ADDR_W'(32'h300 + i * 4);
            cycle();
            chk("t3_accept", obs_wait, 0);
        end
        chk("t3_pending16", pending_beats, 16);
        avs_address = 25'h340;
        repeat (3) begin
            cycle();
            chk("t3_blocked", obs_wait, 1);
        end
        acc5 = 0; kk = 0;
        while (!acc5 && kk < 10) begin
            local_rdata_valid = 1; local_rdata = 32'hD0 + kk;
            cycle();
            if (obs_wait === 1'b0) acc5 = 1;
            else kk++;
        end
        chk("t3_fifth_accepted", acc5, 1);
        chk("t3_returns_before_accept", kk, 4);
        avs_read = 0;
        for (int i = 0; i < 40 && m_pend > 0; i++) begin
            local_rdata_valid = 1; local_rdata = $urandom;
            cycle();
        end
        set_idle();
        cycle();
        chk("t3_drained", pending_beats, 0);

        // 4: return beat coincides with a 2-beat read accept
        avs_read = 1; avs_burstcount = 3'd3; avs_address = 25'h400;
        cycle();
        chk("t4_pending3", pending_beats, 3);
        avs_burstcount = 3'd2; avs_address = 25'h404;
        local_rdata_valid = 1; local_rdata = 32'hCAFE_0001;
        cycle();
        chk("t4_pending", pending_beats, 4);
        chk("t4_rdv", avs_readdatavalid, 1);
        chk("t4_rdata", avs_readdata, 32'hCAFE_0001);
        set_idle();
        repeat (4) begin
            local_rdata_valid = 1; local_rdata = $urandom;
            cycle();
        end
        set_idle();
        cycle();
        chk("t4_drained", pending_beats, 0);

        // 5: calibration not done blocks a held write
        local_init_done = 0;
        avs_write = 1; avs_address = 25'h500; avs_writedata = 32'h5555_AAAA;
        avs_byteenable = 4'h3; avs_burstcount = 3'd1;
        repeat (3) begin
            cycle();
            chk("t5_wait", obs_wait, 1);
            chk("t5_no_wreq", local_write_req, 0);
        end
        local_init_done = 1;
        cycle();
        chk("t5_wreq", local_write_req, 1);
        chk("t5_be", local_be, 4'h3);
        set_idle();
        cycle();

        // 6: reset after beat 2 of a 4-beat burst
        for (int i = 0; i < 2; i++) begin
            avs_write = 1; avs_address = 25'h600; avs_burstcount = 3'd4;
            avs_writedata = 32'hE000_0000 + i; avs_byteenable = 4'hF;
            cycle();
        end
        set_idle(); reset = 1;
        cycle();
        chk("t6_rst_wreq", local_write_req, 0);
        chk("t6_rst_bb", local_burstbegin, 0);
        chk("t6_rst_addr", local_address, 0);
        chk("t6_rst_size", local_size, 0);
        chk("t6_rst_wdata", local_wdata, 0);
        chk("t6_rst_be", local_be, 0);
        reset = 0;
        avs_read = 1; avs_burstcount = 3'd1; avs_address = 25'h700;
        cycle();
        chk("t6_read_wait", obs_wait, 0);
        chk("t6_rreq", local_read_req, 1);
        chk("t6_bb", local_burstbegin, 1);
        set_idle(); local_rdata_valid = 1; local_rdata = 32'h7777_0000;
        cycle();
        chk("t6_no_err_legit", proto_err, 0);
        local_rdata = 32'h7777_0001;
        cycle();
        chk("t6_spurious_err", proto_err, 1);
        chk("t6_no_underflow", pending_beats, 0);
        set_idle();

        // zero burstcount read: one beat, flagged
        reset = 1; cycle(); reset = 0;
        avs_read = 1; avs_burstcount = 3'd0; avs_address = 25'h800;
        cycle();
        chk("bc0_size", local_size, 1);
        chk("bc0_pending", pending_beats, 1);
        chk("bc0_err", proto_err, 1);
        set_idle();
        reset = 1; cycle(); reset = 0;
        chk("rst_err_clear", proto_err, 0);

        // randomized traffic
        owed = 0; mst_active = 0; mst_left = 0;
        for (int c = 0; c < 3000; c++) begin
            local_ready       = ($urandom_range(3) != 0);
            local_init_done   = ($urandom_range(31) != 0);
            local_rdata_valid = (owed > 0) && ($urandom_range(1) == 1);
            local_rdata       = $urandom;
            if (!mst_active) begin
                k = $urandom_range(3);
                avs_read = 0; avs_write = 0;
                avs_address = ADDR_W'($urandom);
                if (k == 1) begin
                    avs_read = 1; mst_active = 1;
                    avs_burstcount = SIZE_W'($urandom_range(1, 7));
                end else if (k == 2) begin
                    avs_write = 1; mst_active = 1;
                    mst_left = $urandom_range(1, 7);
                    avs_burstcount = SIZE_W'(mst_left);
                    avs_writedata = $urandom; avs_byteenable = BE_W'($urandom);
                end
            end
            add = (m_rreq && local_ready) ? m_size : 0;
            cycle();
            owed = owed + add - (local_rdata_valid ? 1 : 0);
            if (m_acc) begin
                if (avs_read) begin
                    mst_active = 0; avs_read = 0;
                end else begin
                    mst_left--;
                    if (mst_left == 0) begin
                        mst_active = 0; avs_write = 0;
                    end else begin
                        avs_writedata = $urandom; avs_byteenable = BE_W'($urandom);
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
